// File: rtl/traffic_phase_ctrl_if.sv
// traffic_phase_ctrl_if
//   Groups the request inputs and the lamp/display outputs of the intersection
//   phase sequencer.
//   master : drives tick, side_req, ped_req, emergency; observes lamps/phase.
//   slave  : the sequencer itself.
//   Signals: tick (1), side_req (1), ped_req (1), emergency (1),
//            main_light (3, {R,Y,G}), side_light (3, {R,Y,G}), phase (3),
//            countdown (CW), ped_walk (1).
interface traffic_phase_ctrl_if #(
  parameter int CW = 8
);
  logic          tick;
  logic          side_req;
  logic          ped_req;
  logic          emergency;
  logic [2:0]    main_light;
  logic [2:0]    side_light;
  logic [2:0]    phase;
  logic [CW-1:0] countdown;
  logic          ped_walk;

  modport master (
    output tick, side_req, ped_req, emergency,
    input  main_light, side_light, phase, countdown, ped_walk
  );

  modport slave (
    input  tick, side_req, ped_req, emergency,
    output main_light, side_light, phase, countdown, ped_walk
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
//   Phase sequencer for a two-road intersection. Timing advances only on the
//   1-cycle tick pulse; main green rests until a side car, a pedestrian or an
//   emergency calls for service. All outputs are registered.
//   Ports: F1 (system clock), rst_n (async active-low reset),
//          bus (traffic_phase_ctrl_if.slave: requests in, lamps/display out).
//
//   state | meaning
//   MG    | main green, rests at countdown 1 until served
//   MY    | main yellow
//   AR1   | all red after main yellow
//   SG    | side green, walk lamp on
//   SY    | side yellow
//   AR2   | all red after side yellow / emergency exit (reset state)
//   EMG   | emergency hold, all red
module traffic_phase_ctrl #(
  parameter int T_MG = 30,
  parameter int T_MY = 3,
  parameter int T_AR = 2,
  parameter int T_SG = 20,
  parameter int T_SY = 3,
  parameter int CW   = 8
) (
  input  logic                 F1,
  input  logic                 rst_n,
  traffic_phase_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5,
    EMG = 3'd6
  } phase_t;

  localparam logic [CW-1:0] L_MG = CW'(T_MG);
  localparam logic [CW-1:0] L_MY = CW'(T_MY);
  localparam logic [CW-1:0] L_AR = CW'(T_AR);
  localparam logic [CW-1:0] L_SG = CW'(T_SG);
  localparam logic [CW-1:0] L_SY = CW'(T_SY);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [2:0]    LR   = 3'b100;
  localparam logic [2:0]    LY   = 3'b010;
  localparam logic [2:0]    LG   = 3'b001;

  phase_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ped_pend_q, ped_pend_d;
  logic          emg_lat_q, emg_lat_d;
  logic [2:0]    main_q, main_d, side_q, side_d;
  logic          walk_q, walk_d;
  logic          expired;

  always_ff @(posedge F1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= AR2;
      cnt_q      <= L_AR;
      ped_pend_q <= 1'b0;
      emg_lat_q  <= 1'b0;
      main_q     <= LR;
      side_q     <= LR;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ped_pend_q <= ped_pend_d;
      emg_lat_q  <= emg_lat_d;
      main_q     <= main_d;
      side_q     <= side_d;
      walk_q     <= walk_d;
    end
  end

  assign expired = (cnt_q <= ONE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    emg_lat_d = emg_lat_q;
    case (state_q)
      MG: begin
        // Emergency forces yellow at once; a coincident tick is ignored.
        if (bus.emergency) begin
          state_d   = MY;
          cnt_d     = L_MY;
          emg_lat_d = 1'b1;
        end else if (bus.tick) begin
          if (!expired)                         cnt_d = cnt_q - ONE;
          else if (bus.side_req || ped_pend_q) begin
            state_d = MY;
            cnt_d   = L_MY;
          end else                              cnt_d = ONE;
        end
      end
      SG: begin
        if (bus.emergency) begin
          state_d   = SY;
          cnt_d     = L_SY;
          emg_lat_d = 1'b1;
        end else if (bus.tick) begin
          if (!expired) cnt_d = cnt_q - ONE;
          else begin
            state_d = SY;
            cnt_d   = L_SY;
          end
        end
      end
      MY, SY: begin
        // Yellow always runs to completion; the latch remembers that an
        // emergency was seen so the exit goes to EMG even if it has dropped.
        if (bus.emergency) emg_lat_d = 1'b1;
        if (bus.tick) begin
          if (!expired) cnt_d = cnt_q - ONE;
          else if (emg_lat_q || bus.emergency) begin
            state_d = EMG;
            cnt_d   = '0;
          end else begin
            state_d = (state_q == MY) ? AR1 : AR2;
            cnt_d   = L_AR;
          end
        end
      end
      AR1, AR2: begin
        if (bus.emergency) begin
          state_d = EMG;
          cnt_d   = '0;
        end else if (bus.tick) begin
          if (!expired) cnt_d = cnt_q - ONE;
          else begin
            state_d = (state_q == AR1) ? SG : MG;
            cnt_d   = (state_q == AR1) ? L_SG : L_MG;
          end
        end
      end
      EMG: begin
        emg_lat_d = 1'b0;
        if (!bus.emergency) begin
          state_d = AR2;
          cnt_d   = L_AR;
        end
      end
      default: begin
        state_d   = AR2;
        cnt_d     = L_AR;
        emg_lat_d = 1'b0;
      end
    endcase
  end

  // Serving the side road serves the pedestrian too; clear beats a new press.
  always_comb begin
    ped_pend_d = ped_pend_q | bus.ped_req;
    if (state_d == SG && state_q != SG) ped_pend_d = 1'b0;
  end

  // Lamps are decoded from the next state so they change with the phase.
  always_comb begin
    main_d = LR;
    side_d = LR;
    walk_d = 1'b0;
    case (state_d)
      MG: main_d = LG;
      MY: main_d = LY;
      SG: begin
        side_d = LG;
        walk_d = 1'b1;
      end
      SY: side_d = LY;
      default: begin
        main_d = LR;
        side_d = LR;
      end
    endcase
  end

  assign bus.phase      = state_q;
  assign bus.countdown  = cnt_q;
  assign bus.main_light = main_q;
  assign bus.side_light = side_q;
  assign bus.ped_walk   = walk_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl
//   Directed scenarios for the phase sequencer with small timing parameters.
//   Stimulus pushes expected phase/countdown into a scoreboard queue; a monitor
//   on the falling clock edge pops and compares, deriving lamps from the phase.
module tb_traffic_phase_ctrl;
  localparam int CW = 8;

  logic F1 = 1'b0;
  logic rst_n;
  always #5 F1 = ~F1;

  traffic_phase_ctrl_if #(.CW(CW)) bus ();

  traffic_phase_ctrl #(
    .T_MG(4), .T_MY(2), .T_AR(1), .T_SG(3), .T_SY(2), .CW(CW)
  ) dut (
    .F1    (F1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string         tag;
    logic [2:0]    ph;
    logic [CW-1:0] cd;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // {main, side, walk} expected for each phase
  function automatic logic [6:0] lamps(input logic [2:0] ph);
    case (ph)
      3'd0:    return {3'b001, 3'b100, 1'b0};
      3'd1:    return {3'b010, 3'b100, 1'b0};
      3'd3:    return {3'b100, 3'b001, 1'b1};
      3'd4:    return {3'b100, 3'b010, 1'b0};
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  task automatic expect_st(input string tag, input int ph, input int cd);
    exp_t e;
    e.tag = tag;
    e.ph  = 3'(ph);
    e.cd  = CW'(cd);
    sb.push_back(e);
  endtask

  task automatic clk_cycle(input bit t);
    @(negedge F1);
    bus.tick = t;
    @(posedge F1);
    #1;
    bus.tick = 1'b0;
  endtask

  task automatic do_tick(input string tag, input int ph, input int cd);
    repeat (3) clk_cycle(1'b0);
    clk_cycle(1'b1);
    expect_st(tag, ph, cd);
  endtask

  // Each entry encodes phase*100 + countdown.
  task automatic run_seq(input string tag, input int seq[$]);
    foreach (seq[i]) do_tick($sformatf("%s[%0d]", tag, i), seq[i] / 100, seq[i] % 100);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [6:0] want;
    forever begin
      @(negedge F1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        want = lamps(e.ph);
        checks++;
        if (bus.phase !== e.ph || bus.countdown !== e.cd) begin
          failures++;
          $display("FAIL %s state: got %0d/%0d expected %0d/%0d",
                   e.tag, bus.phase, bus.countdown, e.ph, e.cd);
        end
        checks++;
        if ({bus.main_light, bus.side_light, bus.ped_walk} !== want) begin
          failures++;
          $display("FAIL %s lamps: got %b/%b walk=%b expected %b/%b walk=%b",
                   e.tag, bus.main_light, bus.side_light, bus.ped_walk,
                   want[6:4], want[3:1], want[0]);
        end
        checks++;
        if ((bus.main_light[0] & bus.side_light[0]) !== 1'b0) begin
          failures++;
          $display("FAIL %s both_green: got main=%b side=%b expected not both G",
                   e.tag, bus.main_light, bus.side_light);
        end
      end
    end
  end

  initial begin : stim
    int s[$];
    rst_n         = 1'b0;
    bus.tick      = 1'b0;
    bus.side_req  = 1'b0;
    bus.ped_req   = 1'b0;
    bus.emergency = 1'b0;
    #2;
    expect_st("reset", 5, 1);
    @(negedge F1);
    #1 rst_n = 1'b1;

    // 1: full cycle with a side car waiting
    bus.side_req = 1'b1;
    s = '{4, 3, 2, 1, 102, 101, 201, 303, 302, 301, 402, 401, 501, 4};
    run_seq("t1", s);
    bus.side_req = 1'b0;

    // 2: main green rests at 1 without requests
    s = '{3, 2, 1};
    run_seq("t2", s);
    repeat (20) do_tick("t2_hold", 0, 1);
    bus.side_req = 1'b1;
    do_tick("t2_serve", 1, 2);
    bus.side_req = 1'b0;

    // 3: pedestrian press during yellow, then pending must be cleared
    bus.ped_req = 1'b1;
    clk_cycle(1'b0);
    bus.ped_req = 1'b0;
    s = '{101, 201, 303, 302, 301, 402, 401, 501, 4, 3, 2, 1, 1, 1, 1};
    run_seq("t3", s);

    // 4: emergency during side green
    bus.side_req = 1'b1;
    do_tick("t4_my", 1, 2);
    bus.side_req = 1'b0;
    s = '{101, 201, 303, 302};
    run_seq("t4", s);
    bus.emergency = 1'b1;
    clk_cycle(1'b0);
    expect_st("t4_force_sy", 4, 2);
    s = '{401, 600, 600};
    run_seq("t4_emg", s);
    bus.emergency = 1'b0;
    clk_cycle(1'b0);
    expect_st("t4_exit", 5, 1);
    do_tick("t4_mg", 0, 4);

    // 5: emergency and tick on the same edge; latch carries through yellow
    do_tick("t5_mg", 0, 3);
    bus.emergency = 1'b1;
    clk_cycle(1'b1);
    bus.emergency = 1'b0;
    expect_st("t5_force_my", 1, 2);
    do_tick("t5_my", 1, 1);
    do_tick("t5_emg", 6, 0);
    clk_cycle(1'b0);
    expect_st("t5_exit", 5, 1);
    do_tick("t5_mg2", 0, 4);

    // 6: asynchronous reset in side yellow
    bus.side_req = 1'b1;
    s = '{3, 2, 1, 102};
    run_seq("t6a", s);
    bus.side_req = 1'b0;
    s = '{101, 201, 303, 302, 301, 402};
    run_seq("t6b", s);
    clk_cycle(1'b0);
    rst_n = 1'b0;
    #1;
    expect_st("t6_async_rst", 5, 1);
    @(negedge F1);
    #1 rst_n = 1'b1;
    do_tick("t6_after", 0, 4);

    repeat (3) @(negedge F1);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d entries left expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
